// File: rtl/bk_mem_arbiter.sv
// Arbitrates the single main-memory port between video, disk DMA and CPU (video > DMA > CPU).
// Define BK_MEM_ARB_STARVE_GUARD_EN to let a starved CPU overtake DMA after STARVE_MAX losses.
module bk_mem_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [15:0]       vid_data,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [15:0]       dma_din,
    output logic              dma_ack,
    output logic [15:0]       dma_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic              cpu_ack,
    output logic [15:0]       cpu_dout,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic [2:0]        grant
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0] state;
    logic       cpu_over;
    logic       win_vid;
    logic       win_dma;
    logic       win_cpu;

`ifdef BK_MEM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign cpu_over = (starve_cnt == 8'(STARVE_MAX));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (win_cpu)
                starve_cnt <= '0;
            else if (win_dma && cpu_req && !cpu_over)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    // STARVE_MAX is 1..255, so this is constant 0: strict priority.
    assign cpu_over = (STARVE_MAX == 0);
`endif

    always_comb begin
        win_vid = vid_req;
        win_dma = !vid_req && dma_req && !(cpu_req && cpu_over);
        win_cpu = !vid_req && cpu_req && (!dma_req || cpu_over);
    end

    assign mem_req = (state == S_ISSUE);
    assign vid_ack = (state == S_DONE) && grant[0];
    assign dma_ack = (state == S_DONE) && grant[1];
    assign cpu_ack = (state == S_DONE) && grant[2];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            grant     <= '0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vid_data  <= '0;
            dma_dout  <= '0;
            cpu_dout  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_vid) begin
                        grant    <= 3'b001;
                        mem_we   <= 1'b0;
                        mem_be   <= '1;
                        mem_addr <= vid_addr;
                        state    <= S_ISSUE;
                    end else if (win_dma) begin
                        grant    <= 3'b010;
                        mem_we   <= dma_we;
                        mem_be   <= '1;
                        mem_addr <= dma_addr;
                        if (dma_we)
                            mem_wdata <= dma_din;
                        state    <= S_ISSUE;
                    end else if (win_cpu) begin
                        grant    <= 3'b100;
                        mem_we   <= cpu_we;
                        mem_be   <= cpu_be;
                        mem_addr <= cpu_addr;
                        if (cpu_we)
                            mem_wdata <= cpu_din;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_ready)
                        state <= mem_we ? S_DONE : S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (mem_rvalid) begin
                        if (grant[0]) vid_data <= mem_rdata;
                        if (grant[1]) dma_dout <= mem_rdata;
                        if (grant[2]) cpu_dout <= mem_rdata;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Self-checking bench for bk_mem_arbiter: vector table, scoreboard queue, memory responder model.
module tb_bk_mem_arbiter;

    typedef struct {
        int          port;   // 0 vid, 1 dma, 2 cpu
        logic        we;
        logic [1:0]  be;
        logic [24:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        int          stall;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        vid_req, dma_req, dma_we, cpu_req, cpu_we;
    logic [24:0] vid_addr, dma_addr, cpu_addr;
    logic [15:0] dma_din, cpu_din;
    logic [1:0]  cpu_be;
    logic        vid_ack, dma_ack, cpu_ack;
    logic [15:0] vid_data, dma_dout, cpu_dout;
    logic        mem_req, mem_ready, mem_we, mem_rvalid;
    logic [1:0]  mem_be;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [2:0]  grant;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    vec_t sb[$];
    vec_t tbl[8];
    bit   sb_en   = 1'b1;
    bit   gap_chk = 1'b0;

    bk_mem_arbiter #(.ADDR_W(25), .STARVE_MAX(8)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_ack(dma_ack), .dma_dout(dma_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .grant(grant)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Monitor: command checked at acceptance, ack/data/latency checked against the queue head.
    vec_t        e;
    logic [2:0]  ackv;
    logic [2:0]  grant_prev = '0;
    int          grant_cyc = 0, acc_cyc = 0, last_ack = 0, burst_acks = 0;
    always @(negedge clk_sys) begin
        ackv = {cpu_ack, dma_ack, vid_ack};
        if (!gap_chk) burst_acks = 0;
        if (sb_en) begin
            if (grant != 3'b000 && grant_prev == 3'b000) begin
                grant_cyc = cyc;
                if (gap_chk && burst_acks > 0) chk("rearb_gap", cyc - last_ack, 2);
            end
            if (mem_req && mem_ready && sb.size() > 0) begin
                e = sb[0];
                chk("acc_grant", {29'd0, grant}, 32'd1 << e.port);
                chk("acc_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("acc_addr", {7'd0, mem_addr}, {7'd0, e.addr});
                chk("acc_be", {30'd0, mem_be}, {30'd0, e.be});
                if (e.we) chk("acc_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
                chk("acc_stall", cyc - grant_cyc, e.stall);
                acc_cyc = cyc;
            end
            if (ackv != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("stray_ack", {29'd0, ackv}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", {29'd0, ackv}, 32'd1 << e.port);
                    chk("ack_lat", cyc - acc_cyc, e.we ? 1 : 1 + e.lat);
                    if (!e.we) begin
                        case (e.port)
                            0: chk("vid_data", {16'd0, vid_data}, {16'd0, e.rdata});
                            1: chk("dma_dout", {16'd0, dma_dout}, {16'd0, e.rdata});
                            default: chk("cpu_dout", {16'd0, cpu_dout}, {16'd0, e.rdata});
                        endcase
                    end
                end
                last_ack = cyc;
                burst_acks++;
            end
        end
        grant_prev = grant;
    end

    // Memory responder: returns the head entry's read data after its latency.
    initial begin
        int          lat;
        logic [15:0] d;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk_sys);
            if (mem_req && mem_ready && !mem_we) begin
                lat = (sb.size() > 0) ? sb[0].lat : 1;
                d   = (sb.size() > 0) ? sb[0].rdata : 16'hDEAD;
                repeat (lat) @(negedge clk_sys);
                mem_rvalid = 1'b1;
                mem_rdata  = d;
                @(negedge clk_sys);
                mem_rvalid = 1'b0;
            end
        end
    end

    task automatic issue(input vec_t v);
        vec_t x;
        x    = v;
        x.be = (v.port == 2) ? v.be : 2'b11;
        sb.push_back(x);
        case (v.port)
            0: begin vid_addr = v.addr; vid_req = 1'b1; end
            1: begin dma_we = v.we; dma_addr = v.addr; dma_din = v.wdata; dma_req = 1'b1; end
            default: begin
                cpu_we = v.we; cpu_be = v.be; cpu_addr = v.addr; cpu_din = v.wdata; cpu_req = 1'b1;
            end
        endcase
    endtask

    task automatic run_until_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk_sys);
            if (vid_ack) vid_req = 1'b0;
            if (dma_ack) dma_req = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
        end
        chk("drain", sb.size(), 0);
        sb.delete();
        vid_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
    endtask

    initial begin
        int dma_n;
        bit cpu_seen;
        vec_t v;
        reset_n = 1'b0; mem_ready = 1'b1;
        vid_req = 0; dma_req = 0; cpu_req = 0; dma_we = 0; cpu_we = 0; cpu_be = '0;
        vid_addr = '0; dma_addr = '0; cpu_addr = '0; dma_din = '0; cpu_din = '0;

        //        port we    be     addr          wdata     rdata    lat stall
        tbl[0] = '{2, 1'b1, 2'b01, 25'h0001234, 16'hABCD, 16'h0000, 0, 0};
        tbl[1] = '{1, 1'b0, 2'b00, 25'h0000100, 16'h0000, 16'h5A5A, 4, 0};
        tbl[2] = '{0, 1'b0, 2'b00, 25'h1FFFFFF, 16'h0000, 16'h1357, 1, 0};
        tbl[3] = '{2, 1'b0, 2'b10, 25'h0000000, 16'h0000, 16'hFFFF, 2, 0};
        tbl[4] = '{1, 1'b1, 2'b00, 25'h00ABCDE, 16'h0F0F, 16'h0000, 0, 0};
        tbl[5] = '{2, 1'b1, 2'b11, 25'h1555555, 16'h8001, 16'h0000, 0, 0};
        tbl[6] = '{0, 1'b0, 2'b00, 25'h0C0C0C0, 16'h0000, 16'hC3A5, 7, 0};
        tbl[7] = '{2, 1'b0, 2'b11, 25'h0000042, 16'h0000, 16'h0001, 1, 0};

        repeat (3) @(negedge clk_sys);
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_mem", {13'd0, mem_req, mem_we, mem_be, mem_wdata}, 32'd0);
        chk("rst_addr", {7'd0, mem_addr}, 32'd0);
        chk("rst_acks", {29'd0, cpu_ack, dma_ack, vid_ack}, 32'd0);
        chk("rst_data", {vid_data, dma_dout | cpu_dout}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i]);
            run_until_empty(40);
        end
        // Read-data registers keep their last own read across other ports' traffic.
        chk("hold_dma_dout", {16'd0, dma_dout}, 32'h5A5A);
        chk("hold_vid_data", {16'd0, vid_data}, 32'hC3A5);
        chk("hold_cpu_dout", {16'd0, cpu_dout}, 32'h0001);

        // Simultaneous requests: served vid, dma, cpu with re-arbitration 2 cycles after each ack.
        gap_chk = 1'b1;
        issue('{0, 1'b0, 2'b00, 25'h0000300, 16'h0000, 16'h7E57, 1, 0});
        issue('{1, 1'b1, 2'b00, 25'h0000301, 16'hBEEF, 16'h0000, 0, 0});
        issue('{2, 1'b0, 2'b01, 25'h0000302, 16'h0000, 16'h2468, 2, 0});
        run_until_empty(60);
        gap_chk = 1'b0;

        // Backpressure: mem_ready low for 10 ISSUE cycles.
        mem_ready = 1'b0;
        issue('{1, 1'b1, 2'b00, 25'h0C0FFEE, 16'h1234, 16'h0000, 0, 10});
        for (int i = 0; i < 10 && grant == 3'b000; i++) @(negedge clk_sys);
        chk("bp_grant", {29'd0, grant}, 32'd2);
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", {5'd0, mem_req, cpu_ack, dma_ack, vid_ack, mem_addr}, {5'd0, 4'b1000, 25'h0C0FFEE});
            if (k < 9) @(negedge clk_sys);
        end
        @(posedge clk_sys);
        #1 mem_ready = 1'b1;
        run_until_empty(20);

        // Reset during WAIT_RD; the late read strobe must be ignored.
        issue('{1, 1'b0, 2'b00, 25'h0000200, 16'h0000, 16'h1111, 20, 0});
        for (int i = 0; i < 10 && !(mem_req && mem_ready); i++) @(negedge clk_sys);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b0;
        dma_req = 1'b0;
        sb.delete();
        #1;
        chk("mrst_grant", {29'd0, grant}, 32'd0);
        chk("mrst_mem", {13'd0, mem_req, mem_we, mem_be, mem_wdata}, 32'd0);
        chk("mrst_dout", {vid_data, dma_dout | cpu_dout}, 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_sys);
            chk("mrst_quiet", {26'd0, mem_req, grant, dma_ack, cpu_ack | vid_ack}, 32'd0);
        end
        chk("mrst_dma_dout", {16'd0, dma_dout}, 32'd0);
        chk("mrst_addr", {7'd0, mem_addr}, 32'd0);

        // Starvation: DMA and CPU writes held continuously.
        sb_en = 1'b0;
        dma_we = 1'b1; dma_addr = 25'h0000400; dma_din = 16'h0404;
        cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 25'h0000500; cpu_din = 16'h0505;
        dma_req = 1'b1; cpu_req = 1'b1;
        dma_n = 0; cpu_seen = 1'b0;
`ifdef BK_MEM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 300 && !cpu_seen; i++) begin
            @(negedge clk_sys);
            if (cpu_ack) cpu_seen = 1'b1;
            else if (dma_ack) dma_n++;
        end
        chk("starve_cpu_seen", {31'd0, cpu_seen}, 32'd1);
        chk("starve_dma_wins", dma_n, 8);
`else
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (cpu_ack) cpu_seen = 1'b1;
            if (dma_ack) dma_n++;
        end
        chk("strict_no_cpu", {31'd0, cpu_seen}, 32'd0);
        chk("strict_dma_count", dma_n, 20);
        dma_req = 1'b0;
        for (int i = 0; i < 10 && !cpu_seen; i++) begin
            @(negedge clk_sys);
            if (cpu_ack) cpu_seen = 1'b1;
        end
        chk("strict_cpu_after", {31'd0, cpu_seen}, 32'd1);
`endif
        dma_req = 1'b0; cpu_req = 1'b0;
        repeat (4) @(negedge clk_sys);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bk_mem_arbiter.md
# bk_mem_arbiter

Shares the single main-memory port between three requesters: the video fetcher, the disk-copy DMA engine and the CPU bus. One access is in flight at a time. Priority is fixed (video > DMA > CPU), with an optional starvation guard that lets the CPU overtake DMA. The block sits between the memory controller and the requester ports of the BK0011M core, replacing direct CPU-only memory access.

## Interface
Parameters:
- ADDR_W, 25, word address width on all ports
- STARVE_MAX, 8, number of consecutive CPU losses to DMA before the CPU takes priority over DMA (guard builds only); range 1..255

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request, level, held until vid_ack
- vid_addr  in  ADDR_W  video word address
- vid_ack  out  1  one-cycle pulse; vid_data valid
- vid_data  out  16  read data, held until next vid_ack
- dma_req  in  1  disk-copy request, level, held until dma_ack
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_W  DMA word address
- dma_din  in  16  DMA write data
- dma_ack  out  1  one-cycle completion pulse
- dma_dout  out  16  DMA read data, held until next DMA read ack
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_be  in  2  byte enables for writes (bit1 = high byte)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_din  in  16  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_dout  out  16  CPU read data, held until next CPU read ack
- mem_req  out  1  command valid to memory
- mem_ready  in  1  memory accepts command when mem_req & mem_ready
- mem_we  out  1  write command
- mem_be  out  2  byte enables (11 for video and DMA)
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data
- mem_rvalid  in  1  one-cycle read data strobe, any latency ≥ 1 after acceptance
- grant  out  3  one-hot current owner {cpu, dma, vid}; 000 when idle

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: pick the winner among asserted requests. Latch its command (we, be, addr, wdata) and set grant. Go to ISSUE. If no request is asserted, stay in IDLE.
- ISSUE: drive mem_req = 1 with the latched command until mem_ready = 1. On acceptance, go to DONE for a write or WAIT_RD for a read.
- WAIT_RD: on mem_rvalid, capture mem_rdata into the owner's data register and go to DONE.
- DONE: pulse the owner's ack for one cycle, clear grant, return to IDLE.
- Priority: video > DMA > CPU.
- The command is latched at grant. Requester inputs changing afterwards have no effect, and the access always completes with an ack.
- mem_rvalid outside WAIT_RD is ignored.
- Write data registers are never modified by reads of other ports.
- Reset (async, any state): state IDLE; all acks, mem_req, mem_we and grant = 0; mem_be = 00; mem_addr, mem_wdata, vid_data, dma_dout and cpu_dout = 0; starve counter = 0. Any in-flight memory read completing after reset is discarded.

## Timing
- Grant decided in IDLE cycle N; mem_req asserted from N+1.
- Write with mem_ready high at N+1: ack at N+2, next grant at N+3.
- Read with mem_ready at N+1 and mem_rvalid at N+1+L: data register updated and ack at N+2+L.
- Peak rate: one access per 3 cycles for writes, 3+L cycles for reads.
- Simultaneous requests in IDLE are resolved in the same cycle; a request arriving during a transfer waits for IDLE.
- A requester that keeps req high after its ack is re-arbitrated in the next IDLE cycle.

## Configuration
- Macro: BK_MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - An 8-bit starve counter increments (saturating at STARVE_MAX) each time DMA wins in IDLE while cpu_req = 1, and clears when the CPU is granted.
  - When the counter equals STARVE_MAX, the CPU beats DMA. Video still wins over both.
- Undefined: strict video > DMA > CPU priority; the counter is not built, and STARVE_MAX is unused.

## Test plan
- Reset mid-read: assert reset_n = 0 in WAIT_RD, release, then pulse mem_rvalid -> no ack, grant = 000, outputs 0.
- Single CPU write: cpu_addr = 0x1234, cpu_be = 01, cpu_din = 0xABCD, mem_ready tied 1 -> mem_req one cycle with mem_be = 01, cpu_ack exactly 2 cycles after grant.
- Read latency: DMA read of 0x00100 with mem_rvalid 4 cycles after acceptance carrying 0x5A5A -> dma_dout = 0x5A5A and dma_ack on the same cycle, 6 cycles after grant.
- Priority: vid_req, dma_req and cpu_req raised in the same cycle -> acks in order vid, dma, cpu.
- Backpressure: mem_ready held 0 for 10 cycles -> mem_req and mem_addr stable throughout; no ack until acceptance.
- Starvation (guard defined, STARVE_MAX = 8): dma_req and cpu_req held continuously -> CPU granted after exactly 8 DMA grants. Guard undefined -> no CPU grant while dma_req is held.
